// File: rtl/const_gen_pkg.sv
// rtl/const_gen_pkg.sv - shared mode codes and prefix FSM encoding for const_gen_unit
//   MODE_*  : 2-bit request mode codes (ZEXT, SEXT, UPPER, PREFIX)
//   cg_state_t : prefix state machine encoding (ST_IDLE, ST_PREFIXED)
package const_gen_pkg;

  localparam logic [1:0] MODE_ZEXT   = 2'b00;
  localparam logic [1:0] MODE_SEXT   = 2'b01;
  localparam logic [1:0] MODE_UPPER  = 2'b10;
  localparam logic [1:0] MODE_PREFIX = 2'b11;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_PREFIXED = 1'b1
  } cg_state_t;

endpackage

// File: rtl/const_ext.sv
// rtl/const_ext.sv - combinational zero/sign/upper extender for 1- or 2-wide immediates
//   value  in  2*IMM_W  immediate; only the low IMM_W bits are used unless wide=1
//   wide   in  1        treat value as a 2*IMM_W-bit immediate
//   sign   in  1        sign-extend from the top valid bit instead of zero-extending
//   upper  in  1        place value[IMM_W-1:0] in the top IMM_W bits, low bits zero
//   result out DATA_W   extended constant
module const_ext
  import const_gen_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 15
) (
  input  logic [2*IMM_W-1:0] value,
  input  logic               wide,
  input  logic               sign,
  input  logic               upper,
  output logic [DATA_W-1:0]  result
);

  logic [DATA_W-1:0] zx;
  logic [DATA_W-1:0] hi_mask;
  logic              sign_bit;

  always_comb begin
    zx       = wide ? DATA_W'(value) : DATA_W'(value[IMM_W-1:0]);
    sign_bit = wide ? value[2*IMM_W-1] : value[IMM_W-1];
    // Ones above the valid width; OR-ing it in sign-extends a negative value.
    hi_mask  = wide ? ({DATA_W{1'b1}} << (2*IMM_W)) : ({DATA_W{1'b1}} << IMM_W);
    if (upper) begin
      result = DATA_W'(value[IMM_W-1:0]) << (DATA_W - IMM_W);
    end else begin
      result = zx | ((sign && sign_bit) ? hi_mask : '0);
    end
  end

endmodule

// File: rtl/const_gen_unit.sv
// rtl/const_gen_unit.sv - pipelined immediate/constant generator with optional prefix mode
//   Optional feature: define CONST_GEN_PREFIX_EN to build the PREFIX mode, its FSM,
//   prefix register and sticky overwrite flag. Without it mode 11 acts as ZEXT.
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous flush: drops the output and any held prefix
//   in_valid/in_ready request handshake; mode/imm request payload
//   out_valid/out_ready result handshake; result DATA_W-bit constant
//   prefix_pending    a prefix is held waiting for its consumer
//   prefix_ovr        sticky: a PREFIX replaced an unconsumed prefix
module const_gen_unit
  import const_gen_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic [IMM_W-1:0]  imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              prefix_pending,
  output logic              prefix_ovr
);

  logic                accept;
  logic                produce;
  logic                wide;
  logic                sign;
  logic                upper;
  logic [2*IMM_W-1:0]  ext_value;
  logic [DATA_W-1:0]   ext_result;

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign sign     = (mode == MODE_SEXT);
  assign upper    = (mode == MODE_UPPER);

`ifdef CONST_GEN_PREFIX_EN
  cg_state_t          state;
  cg_state_t          state_next;
  logic [IMM_W-1:0]   prefix_reg;
  logic               ovr_q;
  logic               is_prefix;

  assign is_prefix = (mode == MODE_PREFIX);
  assign produce   = accept && !is_prefix;
  // UPPER discards a held prefix; ZEXT/SEXT consume it as the high half.
  assign wide      = (state == ST_PREFIXED) && !upper;
  assign ext_value = {prefix_reg, imm};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = ST_IDLE;
    end else if (accept) begin
      state_next = is_prefix ? ST_PREFIXED : ST_IDLE;
    end
  end

  // flush forces in_ready low, so accept never coincides with flush here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prefix_reg <= '0;
      ovr_q      <= 1'b0;
    end else if (accept && is_prefix) begin
      prefix_reg <= imm;
      if (state == ST_PREFIXED) begin
        ovr_q <= 1'b1;
      end
    end
  end

  assign prefix_pending = (state == ST_PREFIXED);
  assign prefix_ovr     = ovr_q;
`else
  assign produce        = accept;
  assign wide           = 1'b0;
  assign ext_value      = {{IMM_W{1'b0}}, imm};
  assign prefix_pending = 1'b0;
  assign prefix_ovr     = 1'b0;
`endif

  const_ext #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_ext (
    .value  (ext_value),
    .wide   (wide),
    .sign   (sign),
    .upper  (upper),
    .result (ext_result)
  );

  // Single output register: a new result replaces the old one in the cycle it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (produce) begin
      out_valid <= 1'b1;
      result    <= ext_result;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_const_gen_unit.sv
// tb/tb_const_gen_unit.sv - directed self-checking bench for const_gen_unit
module tb_const_gen_unit;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mode;
  logic [14:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        prefix_pending;
  logic        prefix_ovr;

  int checks;
  int errors;

  const_gen_unit #(
    .DATA_W (32),
    .IMM_W  (15)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .mode           (mode),
    .imm            (imm),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .result         (result),
    .prefix_pending (prefix_pending),
    .prefix_ovr     (prefix_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request at a negedge; it is taken at the next posedge and
  // the task returns at the following negedge (cycle N+1).
  task automatic drive(input logic [1:0] m, input logic [14:0] i);
    mode     = m;
    imm      = i;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=00000000", result); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (prefix_pending !== 1'b0) begin errors++; $display("FAIL reset_prefix_pending got=%b exp=0", prefix_pending); end
    checks++; if (prefix_ovr !== 1'b0) begin errors++; $display("FAIL reset_prefix_ovr got=%b exp=0", prefix_ovr); end
  endtask

  task automatic test_extend;
    out_ready = 1'b1;
    drive(2'b01, 15'h4000);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sext_valid got=%b exp=1", out_valid); end
    checks++; if (result !== 32'hFFFF_C000) begin errors++; $display("FAIL sext_4000 got=%h exp=ffffc000", result); end
    drive(2'b00, 15'h4000);
    checks++; if (result !== 32'h0000_4000) begin errors++; $display("FAIL zext_4000 got=%h exp=00004000", result); end
    drive(2'b10, 15'h0001);
    checks++; if (result !== 32'h0002_0000) begin errors++; $display("FAIL upper_0001 got=%h exp=00020000", result); end
    drive(2'b10, 15'h7FFF);
    checks++; if (result !== 32'hFFFE_0000) begin errors++; $display("FAIL upper_7fff got=%h exp=fffe0000", result); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
  endtask

`ifdef CONST_GEN_PREFIX_EN
  task automatic test_prefix;
    out_ready = 1'b1;
    drive(2'b11, 15'h0003);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL prefix_no_output got=%b exp=0", out_valid); end
    checks++; if (prefix_pending !== 1'b1) begin errors++; $display("FAIL prefix_pending_set got=%b exp=1", prefix_pending); end
    drive(2'b01, 15'h7FFF);
    checks++; if (result !== 32'h0001_FFFF || out_valid !== 1'b1) begin errors++; $display("FAIL prefix_sext_pos got=%h/%b exp=0001ffff/1", result, out_valid); end
    checks++; if (prefix_pending !== 1'b0) begin errors++; $display("FAIL prefix_pending_clr got=%b exp=0", prefix_pending); end
    drive(2'b11, 15'h4000);
    drive(2'b01, 15'h0000);
    checks++; if (result !== 32'hE000_0000) begin errors++; $display("FAIL prefix_sext_neg got=%h exp=e0000000", result); end
    checks++; if (prefix_ovr !== 1'b0) begin errors++; $display("FAIL ovr_early got=%b exp=0", prefix_ovr); end
    drive(2'b11, 15'h0001);
    drive(2'b11, 15'h0002);
    checks++; if (prefix_ovr !== 1'b1) begin errors++; $display("FAIL ovr_set got=%b exp=1", prefix_ovr); end
    drive(2'b00, 15'h0000);
    checks++; if (result !== 32'h0001_0000) begin errors++; $display("FAIL prefix_zext got=%h exp=00010000", result); end
    drive(2'b11, 15'h0005);
    drive(2'b10, 15'h0001);
    checks++; if (result !== 32'h0002_0000 || prefix_pending !== 1'b0) begin errors++; $display("FAIL prefix_upper got=%h/%b exp=00020000/0", result, prefix_pending); end
    checks++; if (prefix_ovr !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%b exp=1", prefix_ovr); end
    @(negedge clk);
  endtask
`else
  task automatic test_mode11_zext;
    out_ready = 1'b1;
    drive(2'b11, 15'h7FFF);
    checks++; if (out_valid !== 1'b1 || result !== 32'h0000_7FFF) begin errors++; $display("FAIL mode11_zext got=%h/%b exp=00007fff/1", result, out_valid); end
    checks++; if (prefix_pending !== 1'b0 || prefix_ovr !== 1'b0) begin errors++; $display("FAIL mode11_flags got=%b%b exp=00", prefix_pending, prefix_ovr); end
    @(negedge clk);
  endtask
`endif

  task automatic test_back_pressure;
    out_ready = 1'b0;
    drive(2'b01, 15'h0005);
    checks++; if (out_valid !== 1'b1 || result !== 32'h0000_0005) begin errors++; $display("FAIL stall_first got=%h/%b exp=00000005/1", result, out_valid); end
    mode = 2'b00; imm = 15'h0011; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", c, in_ready); end
      @(negedge clk);
      checks++; if (result !== 32'h0000_0005 || out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold cyc=%0d got=%h/%b exp=00000005/1", c, result, out_valid); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (result !== 32'h0000_0011 || out_valid !== 1'b1) begin errors++; $display("FAIL release_accept got=%h/%b exp=00000011/1", result, out_valid); end
    @(negedge clk);
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    drive(2'b01, 15'h0009);
    flush = 1'b1; mode = 2'b00; imm = 15'h0022; in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    out_ready = 1'b1;
`ifdef CONST_GEN_PREFIX_EN
    drive(2'b11, 15'h7FFF);
    flush = 1'b1; mode = 2'b01; imm = 15'h0002; in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (prefix_pending !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_prefix got=%b/%b exp=0/0", prefix_pending, out_valid); end
    checks++; if (prefix_ovr !== 1'b1) begin errors++; $display("FAIL flush_keeps_ovr got=%b exp=1", prefix_ovr); end
`endif
    drive(2'b01, 15'h0001);
    checks++; if (result !== 32'h0000_0001 || out_valid !== 1'b1) begin errors++; $display("FAIL post_flush got=%h/%b exp=00000001/1", result, out_valid); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    drive(2'b01, 15'h4000);
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || result !== 32'h0) begin errors++; $display("FAIL midreset_out got=%h/%b exp=00000000/0", result, out_valid); end
    checks++; if (prefix_pending !== 1'b0 || prefix_ovr !== 1'b0) begin errors++; $display("FAIL midreset_flags got=%b%b exp=00", prefix_pending, prefix_ovr); end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    mode      = 2'b00;
    imm       = '0;
    out_ready = 1'b1;
    test_reset;
    test_extend;
`ifdef CONST_GEN_PREFIX_EN
    test_prefix;
`else
    test_mode11_zext;
`endif
    test_back_pressure;
    test_flush;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
